mtm_alu_deserializer: RTL and testbench
=======================================

Name: mtm_alu_deserializer

Overview:
Serial front end of the ALU datapath. It receives the single-line serial input one bit per clk and assembles each packet into operands A and B and a control byte. It checks packet structure and the 4-bit packet CRC, then presents A, B and CTL to the ALU core for exactly one cycle. On malformed or corrupted packets it emits an error control code instead; the core passes that code through unchanged.

Parameters:
IDLE_CTL, 8'hFF, CTL value driven whenever no packet result is being presented
ERR_DATA, 8'hC9, CTL code for structural errors (wrong byte count, bad stop bit)
ERR_CRC, 8'hA5, CTL code for CRC mismatch

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
sin  input  1  serial input, idles high, sampled on every posedge clk
A  output  32  operand A, registered
B  output  32  operand B, registered
CTL  output  8  {1'b0, OP[2:0], CRC[3:0]} on success, error code on failure, IDLE_CTL otherwise; registered
valid  output  1  one-cycle pulse, coincident with any non-idle CTL

Behaviour:
- Reset: A=0, B=0, CTL=IDLE_CTL, valid=0. Byte counter, overflow flag and shift register cleared. FSM goes to IDLE. A reset mid-packet discards all partial data.
- Frame is 11 bits, one per cycle: start(0), flag (0=data, 1=command), 8 payload bits MSB first, stop(1).
- Packet is 8 data frames followed by 1 command frame.
  - Data byte order: B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] … A[7:0].
  - Command payload is {1'b0, OP[2:0], CRC[3:0]}.
- FSM states:
  - IDLE: sin=0 → FLAG, else stay.
  - FLAG: latch flag → DATA, bit counter=7.
  - DATA: shift in 8 bits → STOP.
  - STOP: if sin=1, process the frame → IDLE. If sin=0 (framing error) → WAIT_HIGH.
  - WAIT_HIGH: stay until sin=1 → IDLE. This prevents a stuck-low line being decoded as a start bit.
- Start bit may immediately follow a stop bit (back-to-back frames, no idle gap required).
- Data frame processed: if count<8, store byte into position count and count+1. If count already 8, set overflow flag; count stays 8.
- Command frame processed:
  - Count≠8 or overflow set → CTL=ERR_DATA.
  - Else compute CRC-4 over the 68-bit vector {B, A, 1'b1, OP}:
    - polynomial x^4+x+1, init 0, MSB first
    - per bit: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000)
  - Mismatch with received CRC → CTL=ERR_CRC.
  - Match → A, B updated, CTL = received command byte.
  - In all three cases: valid=1, then count and overflow cleared.
- Framing error (bad stop bit): CTL=ERR_DATA with valid=1 in the cycle after the stop bit is sampled. Count and overflow cleared; the partial packet is discarded.
- Latency: CTL/valid asserted in the cycle immediately after the stop bit is sampled, held exactly 1 cycle, then CTL returns to IDLE_CTL.
- On error codes A and B hold their previous values.
- CRC may be computed serially or combinationally. The result must be available without delaying the output beyond the stated latency.
- Minimum packet length: 99 cycles. Throughput: one result per packet.

Test Plan:
- Reset, then 8 zero data frames and command 8'h0B (OP=AND, CRC=4'b1011) → one cycle after the final stop bit: valid=1, A=0, B=0, CTL=8'h0B. Next cycle CTL=8'hFF, valid=0.
- Same packet but command 8'h0A → CTL=8'hA5 for one cycle. A and B keep their prior values.
- Only 7 data frames, then command 8'h0B → CTL=8'hC9 for one cycle. A following correct 8+1 packet yields CTL=8'h0B.
- 9 zero data frames, then command 8'h0B → CTL=8'hC9. Counter recovers on the next packet.
- Data frame with stop bit 0 and sin held low 5 more cycles → CTL=8'hC9 one cycle after the stop bit, no spurious start detected until sin returns high, next valid packet decodes correctly.
- rst_n asserted low for 1 cycle after the 4th data byte, then a full zero packet with command 8'h0B → CTL=8'h0B with no ERR_DATA. Two back-to-back packets with no idle bits → two valid pulses 99 cycles apart.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// Serial packet deserializer for the ALU: assembles 8 data frames plus one command frame
// into A, B and CTL, checking framing, byte count and the CRC-4 before presenting a result.
module mtm_alu_deserializer #(
  parameter logic [7:0] IDLE_CTL = 8'hFF,
  parameter logic [7:0] ERR_DATA = 8'hC9,
  parameter logic [7:0] ERR_CRC  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [7:0]  CTL,
  output logic        valid
);

  typedef enum logic [2:0] {StIdle, StFlag, StData, StStop, StWaitHigh} state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        flag_q, flag_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic        ovf_q, ovf_d;
  logic [63:0] data_q, data_d;
  logic [31:0] a_d, b_d;
  logic [7:0]  ctl_d;
  logic        valid_d;
  logic [2:0]  byte_idx;
  logic [3:0]  crc_calc;

  // Serial CRC-4 (x^4+x+1, init 0, MSB first) unrolled into one combinational pass.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] crc;
    logic       fb;
    crc = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ msg[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return crc;
  endfunction

  assign byte_idx = 3'(3'd7 - byte_cnt_q[2:0]);
  assign crc_calc = crc4({data_q, 1'b1, shift_q[6:4]});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      flag_q     <= 1'b0;
      shift_q    <= 8'd0;
      byte_cnt_q <= 4'd0;
      ovf_q      <= 1'b0;
      data_q     <= 64'd0;
      A          <= 32'd0;
      B          <= 32'd0;
      CTL        <= IDLE_CTL;
      valid      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      flag_q     <= flag_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      A          <= a_d;
      B          <= b_d;
      CTL        <= ctl_d;
      valid      <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    flag_d     = flag_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d      = ovf_q;
    data_d     = data_q;
    a_d        = A;
    b_d        = B;
    ctl_d      = IDLE_CTL;
    valid_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!sin) state_d = StFlag;
      end
      StFlag: begin
        flag_d    = sin;
        bit_cnt_d = 3'd7;
        state_d   = StData;
      end
      StData: begin
        shift_d   = {shift_q[6:0], sin};
        bit_cnt_d = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0) state_d = StStop;
      end
      StStop: begin
        if (sin) begin
          state_d = StIdle;
          if (!flag_q) begin
            if (byte_cnt_q < 4'd8) begin
              // First byte lands in B[31:24], i.e. the top of the {B, A} buffer.
              data_d[{byte_idx, 3'b000} +: 8] = shift_q;
              byte_cnt_d = byte_cnt_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            valid_d    = 1'b1;
            byte_cnt_d = 4'd0;
            ovf_d      = 1'b0;
            if (byte_cnt_q != 4'd8 || ovf_q) begin
              ctl_d = ERR_DATA;
            end else if (crc_calc != shift_q[3:0]) begin
              ctl_d = ERR_CRC;
            end else begin
              ctl_d = shift_q;
              b_d   = data_q[63:32];
              a_d   = data_q[31:0];
            end
          end
        end else begin
          // Bad stop bit: report now, then wait for the line to recover before hunting starts.
          state_d    = StWaitHigh;
          valid_d    = 1'b1;
          ctl_d      = ERR_DATA;
          byte_cnt_d = 4'd0;
          ovf_d      = 1'b0;
        end
      end
      StWaitHigh: begin
        if (sin) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed and randomized checks of mtm_alu_deserializer against a byte-queue packet model
// with a polynomial-division CRC reference.
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [7:0]  CTL;
  logic        valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pulse = -1;
  int prev_pulse = -1;

  logic [7:0]  q[$];
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  mtm_alu_deserializer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sin  (sin),
    .A    (A),
    .B    (B),
    .CTL  (CTL),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of (msg * x^4) divided by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      sin = v;
      @(posedge clk);
      #1;
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_ctl", 32'(CTL), 32'hFF);
    end
  endtask

  task automatic send_frame(input logic flag, input logic [7:0] pay, input logic stop);
    logic [10:0] bits;
    logic        ev;
    logic [7:0]  ec;
    bits = {1'b0, flag, pay, stop};
    for (int i = 0; i < 11; i++) begin
      sin = bits[10-i];
      @(posedge clk);
      #1;
      if (i < 10) begin
        chk("mid_valid", 32'(valid), 32'd0);
        chk("mid_ctl", 32'(CTL), 32'hFF);
      end
    end
    ev = 1'b0;
    ec = 8'hFF;
    if (!stop) begin
      ev = 1'b1;
      ec = 8'hC9;
      q.delete();
    end else if (!flag) begin
      q.push_back(pay);
    end else begin
      ev = 1'b1;
      if (q.size() != 8) begin
        ec = 8'hC9;
      end else begin
        logic [31:0] pb, pa;
        pb = {q[0], q[1], q[2], q[3]};
        pa = {q[4], q[5], q[6], q[7]};
        if (ref_crc({pb, pa, 1'b1, pay[6:4]}) == pay[3:0]) begin
          ec    = pay;
          exp_a = pa;
          exp_b = pb;
        end else begin
          ec = 8'hA5;
        end
      end
      q.delete();
    end
    chk("stop_valid", 32'(valid), 32'(ev));
    chk("stop_ctl", 32'(CTL), 32'(ec));
    chk("stop_a", A, exp_a);
    chk("stop_b", B, exp_b);
  endtask

  task automatic zero_packet(input int n, input logic [7:0] cmd);
    for (int k = 0; k < n; k++) send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b1, cmd, 1'b1);
  endtask

  task automatic rand_packet(input logic corrupt);
    logic [63:0] d;
    logic [2:0]  op;
    logic [3:0]  crc;
    d = {$urandom, $urandom};
    for (int k = 0; k < 8; k++) send_frame(1'b0, d[63-8*k -: 8], 1'b1);
    op  = 3'($urandom_range(0, 7));
    crc = ref_crc({d, 1'b1, op});
    if (corrupt) crc = crc ^ 4'($urandom_range(1, 15));
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    exp_a = 32'd0;
    exp_b = 32'd0;
    chk("rst_a", A, 32'd0);
    chk("rst_b", B, 32'd0);
    chk("rst_ctl", 32'(CTL), 32'hFF);
    chk("rst_valid", 32'(valid), 32'd0);
  endtask

  initial begin
    int gap;
    rst_n = 1'b0;
    sin   = 1'b1;
    exp_a = 32'd0;
    exp_b = 32'd0;
    do_reset(2);
    idle(3, 1'b1);

    // Good zero packet, then CRC-corrupted one.
    zero_packet(8, 8'h0B);
    idle(1, 1'b1);
    zero_packet(8, 8'h0A);
    idle(1, 1'b1);

    // Too few, then too many data frames; each followed by a good packet.
    zero_packet(7, 8'h0B);
    idle(1, 1'b1);
    rand_packet(1'b0);
    idle(1, 1'b1);
    zero_packet(9, 8'h0B);
    idle(1, 1'b1);
    rand_packet(1'b0);
    idle(1, 1'b1);
    zero_packet(8, 8'h0B);

    // Framing error with the line held low afterwards.
    send_frame(1'b0, 8'h5A, 1'b0);
    idle(5, 1'b0);
    idle(2, 1'b1);
    zero_packet(8, 8'h0B);
    idle(1, 1'b1);

    // Reset mid-packet after four data bytes.
    rand_packet(1'b0);
    for (int k = 0; k < 4; k++) send_frame(1'b0, 8'(k + 1), 1'b1);
    do_reset(1);
    zero_packet(8, 8'h0B);

    // Back-to-back packets with no idle bits.
    rand_packet(1'b0);
    rand_packet(1'b0);
    gap = last_pulse - prev_pulse;
    chk("b2b_gap", 32'(gap), 32'd99);

    // Random mix of good and corrupted packets.
    for (int n = 0; n < 12; n++) begin
      rand_packet(1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
